// File: rtl/vjtag_readback_if.sv
// Bus bundle for the virtual JTAG readback block: NPU push side in the
// system clock domain plus the virtual JTAG instance controls on tck.
interface vjtag_readback_if #(
    parameter int DATA_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              overflow;
    logic              tdi;
    logic [1:0]        ir_in;
    logic              v_cdr;
    logic              v_sdr;
    logic              v_udr;
    logic              tdo;

    modport master (
        output wr_en, wr_data, tdi, ir_in, v_cdr, v_sdr, v_udr,
        input  full, overflow, tdo
    );

    modport slave (
        input  wr_en, wr_data, tdi, ir_in, v_cdr, v_sdr, v_udr,
        output full, overflow, tdo
    );
endinterface

// File: rtl/vjtag_readback.sv
// Device-to-host return path for the virtual JTAG link. Result words are
// pushed into an asynchronous FIFO on clk and pulled out by the host
// through DR scans on tck. Pointers cross domains as Gray code through
// two-flop synchronizers; the full/overflow flags are re-synchronized
// into tck so the host can read them in the STATUS word.
module vjtag_readback #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic               clk,
    input  logic               tck,
    input  logic               aclr,
    vjtag_readback_if.slave    bus
);
    localparam int         AW        = $clog2(DEPTH);
    localparam int         SR_W      = DATA_W + 1;
    localparam logic [1:0] IR_STATUS = 2'd1;
    localparam logic [1:0] IR_DATA   = 2'd2;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

    // ---------------- clk domain ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr_r;
    logic [AW:0]       wgray_r;
    logic [AW:0]       rsync1_r;
    logic [AW:0]       rsync2_r;
    logic              full_r;
    logic              overflow_r;

    logic              push_s;
    logic [AW:0]       wptr_next_s;
    logic [AW:0]       rptr_wclk_s;
    logic              full_next_s;

    // ---------------- tck domain ----------------
    logic [AW:0]       rptr_r;
    logic [AW:0]       rgray_r;
    logic [AW:0]       wsync1_r;
    logic [AW:0]       wsync2_r;
    logic              ovf_sync1_r;
    logic              ovf_sync2_r;
    logic              full_sync1_r;
    logic              full_sync2_r;
    logic [SR_W-1:0]   sr_r;
    logic              bypass_r;
    logic              cap_valid_r;

    logic [AW:0]       wptr_tck_s;
    logic [AW:0]       count_s;
    logic              empty_s;
    logic [SR_W-1:0]   status_s;
    logic [DATA_W-1:0] rd_word_s;
    logic              pop_s;
    logic [AW:0]       rptr_next_s;
    logic              ir_sel_s;

    // Write-side next pointer and full prediction against the synced read pointer
    always_comb begin
        push_s      = bus.wr_en & ~full_r;
        wptr_next_s = wptr_r + {{AW{1'b0}}, push_s};
        rptr_wclk_s = gray2bin(rsync2_r);
        full_next_s = (wptr_next_s == {~rptr_wclk_s[AW], rptr_wclk_s[AW-1:0]});
    end

    // FIFO storage write; contents need no reset since pointers gate every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem[wptr_r[AW-1:0]] <= bus.wr_data;
        end
    end

    // Write pointer, its Gray copy, registered full and sticky overflow
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            wptr_r     <= {(AW+1){1'b0}};
            wgray_r    <= {(AW+1){1'b0}};
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            wptr_r  <= wptr_next_s;
            wgray_r <= bin2gray(wptr_next_s);
            full_r  <= full_next_s;
            if (bus.wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Bring the read pointer Gray code into the clk domain
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            rsync1_r <= {(AW+1){1'b0}};
            rsync2_r <= {(AW+1){1'b0}};
        end else begin
            rsync1_r <= rgray_r;
            rsync2_r <= rsync1_r;
        end
    end

    // Read-side occupancy, status word and pop decision (cdr > sdr > udr)
    always_comb begin
        wptr_tck_s  = gray2bin(wsync2_r);
        count_s     = wptr_tck_s - rptr_r;
        empty_s     = (count_s == {(AW+1){1'b0}});
        status_s    = {SR_W{1'b0}};
        status_s[AW+3:0] = {count_s, ovf_sync2_r, full_sync2_r, empty_s};
        rd_word_s   = mem[rptr_r[AW-1:0]];
        pop_s       = ~bus.v_cdr & ~bus.v_sdr & bus.v_udr &
                      (bus.ir_in == IR_DATA) & cap_valid_r;
        rptr_next_s = rptr_r + {{AW{1'b0}}, pop_s};
        ir_sel_s    = (bus.ir_in == IR_STATUS) || (bus.ir_in == IR_DATA);
    end

    // Read pointer and its Gray copy, advanced by a confirmed DATA update
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            rptr_r  <= {(AW+1){1'b0}};
            rgray_r <= {(AW+1){1'b0}};
        end else begin
            rptr_r  <= rptr_next_s;
            rgray_r <= bin2gray(rptr_next_s);
        end
    end

    // Bring the write pointer and the write-side flags into the tck domain
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            wsync1_r     <= {(AW+1){1'b0}};
            wsync2_r     <= {(AW+1){1'b0}};
            ovf_sync1_r  <= 1'b0;
            ovf_sync2_r  <= 1'b0;
            full_sync1_r <= 1'b0;
            full_sync2_r <= 1'b0;
        end else begin
            wsync1_r     <= wgray_r;
            wsync2_r     <= wsync1_r;
            ovf_sync1_r  <= overflow_r;
            ovf_sync2_r  <= ovf_sync1_r;
            full_sync1_r <= full_r;
            full_sync2_r <= full_sync1_r;
        end
    end

    // DR shift register: capture status or data word, shift LSB first, retire on pop
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            sr_r        <= {SR_W{1'b0}};
            cap_valid_r <= 1'b0;
        end else if (bus.v_cdr) begin
            case (bus.ir_in)
                IR_STATUS: begin
                    sr_r        <= status_s;
                    cap_valid_r <= 1'b0;
                end
                IR_DATA: begin
                    if (!empty_s) begin
                        sr_r        <= {rd_word_s, 1'b1};
                        cap_valid_r <= 1'b1;
                    end else begin
                        sr_r        <= {SR_W{1'b0}};
                        cap_valid_r <= 1'b0;
                    end
                end
                default: begin
                    cap_valid_r <= 1'b0;
                end
            endcase
        end else if (bus.v_sdr) begin
            if (ir_sel_s) begin
                sr_r <= {bus.tdi, sr_r[SR_W-1:1]};
            end
        end else if (pop_s) begin
            cap_valid_r <= 1'b0;
        end
    end

    // One-bit bypass path for the unused IR codes
    always_ff @(posedge tck or negedge aclr) begin
        if (!aclr) begin
            bypass_r <= 1'b0;
        end else begin
            bypass_r <= bus.tdi;
        end
    end

    assign bus.tdo      = ir_sel_s ? sr_r[0] : bypass_r;
    assign bus.full     = full_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_vjtag_readback.sv
// Scoreboard bench for vjtag_readback: stimulus pushes expected values from a
// queue-based model into exp_q; a monitor pairs them with observed DUT results.
module tb_vjtag_readback;
    localparam int         DATA_W    = 8;
    localparam int         DEPTH     = 16;
    localparam int         SR_W      = DATA_W + 1;
    localparam logic [1:0] IR_BYP    = 2'd0;
    localparam logic [1:0] IR_STATUS = 2'd1;
    localparam logic [1:0] IR_DATA   = 2'd2;

    typedef struct {
        string           name;
        logic [SR_W-1:0] val;
    } exp_t;

    logic clk  = 1'b0;
    logic tck  = 1'b0;
    logic aclr = 1'b0;

    vjtag_readback_if #(.DATA_W(DATA_W)) bus ();

    vjtag_readback #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .tck  (tck),
        .aclr (aclr),
        .bus  (bus)
    );

    always #3 clk = ~clk;
    initial begin
        #1;
        forever #7 tck = ~tck;
    end

    exp_t              exp_q [$];
    logic [SR_W-1:0]   got_q [$];
    logic [DATA_W-1:0] model_q [$];
    bit                model_ovf = 1'b0;
    int                chk_cnt   = 0;
    int                pass_cnt  = 0;

    // Monitor: pair each observed DUT result with the oldest expectation
    initial begin : monitor
        logic [SR_W-1:0] g;
        exp_t            e;
        forever begin
            @(negedge tck);
            while (got_q.size() > 0) begin
                g = got_q.pop_front();
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_output got=%h expected=none", g);
                end else begin
                    e = exp_q.pop_front();
                    if (g === e.val) pass_cnt++;
                    else $display("FAIL %s got=%h expected=%h", e.name, g, e.val);
                end
            end
        end
    end

    // Status word from model occupancy and flags
    function automatic logic [SR_W-1:0] status_exp();
        int n;
        int v;
        n = model_q.size();
        v = n * 8 + (model_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0);
        return 9'(v);
    endfunction

    task automatic expect_val(input string name, input logic [SR_W-1:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [SR_W-1:0] v);
        got_q.push_back(v);
    endtask

    task automatic post(input string name, input logic [SR_W-1:0] e, input logic [SR_W-1:0] g);
        expect_val(name, e);
        observe(g);
    endtask

    task automatic idle_tck(input int n);
        repeat (n) @(posedge tck);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        @(posedge clk); #1;
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        if (model_q.size() < DEPTH) model_q.push_back(d);
        else model_ovf = 1'b1;
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
    endtask

    task automatic scan(input logic [1:0] ir, output logic [SR_W-1:0] v);
        @(posedge tck); #1;
        bus.ir_in = ir;
        bus.v_cdr = 1'b1;
        @(posedge tck); #1;
        bus.v_cdr = 1'b0;
        bus.v_sdr = 1'b1;
        for (int i = 0; i < SR_W; i++) begin
            v[i]    = bus.tdo;
            bus.tdi = 1'($urandom_range(0, 1));
            @(posedge tck); #1;
        end
        bus.v_sdr = 1'b0;
        bus.v_udr = 1'b1;
        @(posedge tck); #1;
        bus.v_udr = 1'b0;
    endtask

    task automatic data_scan(input string name);
        logic [SR_W-1:0] v;
        if (model_q.size() > 0) expect_val(name, {model_q.pop_front(), 1'b1});
        else expect_val(name, {SR_W{1'b0}});
        scan(IR_DATA, v);
        observe(v);
    endtask

    task automatic status_scan(input string name);
        logic [SR_W-1:0] v;
        expect_val(name, status_exp());
        scan(IR_STATUS, v);
        observe(v);
    endtask

    initial begin : stim
        logic [DATA_W-1:0] w;
        logic [3:0]        pat;
        int                rx;
        int                scans;
        int                guard;
        logic [SR_W-1:0]   v;
        logic [DATA_W-1:0] d;

        bus.wr_en = 1'b0; bus.wr_data = '0; bus.tdi = 1'b0; bus.ir_in = IR_BYP;
        bus.v_cdr = 1'b0; bus.v_sdr = 1'b0; bus.v_udr = 1'b0;
        aclr = 1'b0;
        #47;
        aclr = 1'b1;
        idle_tck(3);

        // reset state
        post("rst_full", 9'd0, 9'(bus.full));
        post("rst_overflow", 9'd0, 9'(bus.overflow));
        post("rst_tdo", 9'd0, 9'(bus.tdo));
        status_scan("rst_status");

        // basic ordered readback
        push(8'hA5); push(8'h3C); push(8'h7E);
        idle_tck(5);
        data_scan("rd_a5"); data_scan("rd_3c"); data_scan("rd_7e");
        idle_tck(3);
        status_scan("status_after_drain");

        // empty read
        data_scan("empty_data");
        idle_tck(2);
        status_scan("empty_status");

        // fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) push(8'(i));
        post("full_after_16", 9'd1, 9'(bus.full));
        push(8'hFF);
        post("overflow_set", 9'd1, 9'(bus.overflow));
        post("full_held", 9'd1, 9'(bus.full));
        idle_tck(6);
        status_scan("status_full");
        data_scan("fill_rd0");
        repeat (3) @(posedge clk);
        #1;
        post("full_release", 9'd0, 9'(bus.full));
        for (int i = 1; i < DEPTH; i++) data_scan("fill_rd");
        idle_tck(6);
        status_scan("status_after_fill");

        // aborted pop: capture DATA, switch IR before update
        w = 8'($urandom);
        push(w);
        idle_tck(5);
        @(posedge tck); #1;
        bus.ir_in = IR_DATA; bus.v_cdr = 1'b1;
        @(posedge tck); #1;
        bus.v_cdr = 1'b0; bus.ir_in = IR_STATUS; bus.v_udr = 1'b1;
        @(posedge tck); #1;
        bus.v_udr = 1'b0;
        data_scan("abort_same_word");
        idle_tck(3);
        status_scan("abort_status");

        // bypass
        bus.ir_in = IR_BYP;
        pat = 4'b1011;
        idle_tck(2);
        for (int i = 3; i >= 0; i--) begin
            bus.tdi = pat[i];
            @(posedge tck); #1;
            post("bypass_bit", 9'(pat[i]), 9'(bus.tdo));
        end

        // reset in the middle of a DATA shift
        push(8'($urandom)); push(8'($urandom));
        idle_tck(5);
        @(posedge tck); #1;
        bus.ir_in = IR_DATA; bus.v_cdr = 1'b1;
        @(posedge tck); #1;
        bus.v_cdr = 1'b0; bus.v_sdr = 1'b1; bus.tdi = 1'b1;
        repeat (4) @(posedge tck);
        #3;
        aclr = 1'b0;
        bus.v_sdr = 1'b0;
        #2;
        post("midrst_tdo", 9'd0, 9'(bus.tdo));
        model_q.delete();
        model_ovf = 1'b0;
        #4;
        aclr = 1'b1;
        idle_tck(3);
        post("midrst_full", 9'd0, 9'(bus.full));
        post("midrst_overflow", 9'd0, 9'(bus.overflow));
        status_scan("midrst_status");
        data_scan("midrst_data");

        // concurrent pushes and pops across the pointer wrap
        rx = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    d = 8'($urandom);
                    guard = 0;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    @(posedge clk); #1;
                    while (bus.full && guard < 2000) begin
                        @(posedge clk); #1;
                        guard++;
                    end
                    bus.wr_en = 1'b1;
                    bus.wr_data = d;
                    expect_val("wrap_word", {d, 1'b1});
                    @(posedge clk); #1;
                    bus.wr_en = 1'b0;
                end
            end
            begin
                scans = 0;
                while (rx < 40 && scans < 1000) begin
                    scan(IR_DATA, v);
                    scans++;
                    if (v[0]) begin
                        observe(v);
                        rx++;
                    end
                end
            end
        join
        idle_tck(2);
        post("wrap_rx_count", 9'd40, 9'(rx));
        idle_tck(8);
        status_scan("final_status");

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 50 && got_q.size() != 0; i++) @(posedge tck);
        @(posedge tck);
        chk_cnt++;
        if (exp_q.size() == 0 && got_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain pending_expected=%0d pending_observed=%0d required=0", exp_q.size(), got_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/vjtag_readback.md
Name: vjtag_readback

Overview:
Device-to-host return path for the virtual JTAG link. NPU-side logic pushes result words into an asynchronous FIFO on the system clock. The host pulls the words out through Virtual JTAG DR scans on tck, and can also scan a status word. The block sits beside the host-to-device vjtag write path and shares the same virtual JTAG instance control signals (IR, capture/shift/update strobes).

Parameters:
DATA_W, 8, width of one result word
DEPTH, 16, FIFO entries; power of 2; AW = log2(DEPTH); AW+4 <= DATA_W+1 required

Ports:
clk  in  1  system clock, write side
tck  in  1  JTAG clock from virtual JTAG instance
aclr  in  1  reset, asynchronous, active-low; resets both clock domains
wr_en  in  1  push request (clk domain)
wr_data  in  DATA_W  word to push
full  out  1  FIFO full (clk domain, registered)
overflow  out  1  sticky: push attempted while full (clk domain)
tdi  in  1  serial data from host
ir_in  in  2  virtual IR: 0 bypass, 1 STATUS, 2 DATA, 3 bypass
v_cdr  in  1  capture-DR strobe (tck domain)
v_sdr  in  1  shift-DR state (tck domain)
v_udr  in  1  update-DR strobe, one tck cycle (tck domain)
tdo  out  1  serial data to host

Behaviour:
- Reset (aclr low, async):
  - wptr, rptr and both synchronizer chains = 0
  - full = 0, overflow = 0
  - shift register sr[DATA_W:0] = 0, bypass reg = 0, cap_valid = 0, tdo = 0
  - FIFO contents are don't-care
- Reset mid-scan or mid-push: reset aborts the operation and discards all queued data.
- Pointers:
  - AW+1 bits binary, with Gray copies crossing domains.
  - Each crossing uses a 2-flop synchronizer in the destination clock.
- Write side (posedge clk):
  - wr_en && !full: mem[wptr] <= wr_data; wptr++.
  - wr_en && full: word dropped, pointer unchanged, overflow <= 1. overflow stays set until aclr.
  - full is registered: it asserts on the same edge that stores the DEPTH-th entry, from wptr_next vs the synced rptr.
  - full deasserts no later than 3 clk edges after the popping tck edge.
- JTAG side (posedge tck):
  - count = wptr_sync - rptr (AW+1 bits).
  - empty = (count == 0).
  - bypass_reg <= tdi every cycle.
- v_cdr, IR=STATUS:
  - sr <= zero-extended {count, overflow_sync, full_sync, empty}.
  - empty = bit0, full_sync = bit1, overflow_sync = bit2, count = bits [AW+3:3].
  - overflow and full are each re-synchronized by 2 flops.
- v_cdr, IR=DATA:
  - Non-empty: sr <= {mem[rptr], 1'b1}; cap_valid <= 1.
  - Empty: sr <= 0; cap_valid <= 0.
- v_cdr with IR 0 or 3: sr unchanged; cap_valid <= 0.
- v_sdr with IR 1 or 2: sr <= {tdi, sr[DATA_W:1]}. Shifting is LSB first; the host scans DATA_W+1 bits.
- v_udr with IR=DATA and cap_valid: rptr++ (pop); cap_valid <= 0.
- v_udr in any other case: no pop.
- IR change between capture and update: no pop, and cap_valid is cleared on the next v_cdr.
- tdo is combinational: sr[0] when IR is 1 or 2; bypass_reg otherwise.
- Latency: a word pushed at clk edge N is visible (empty = 0) at a capture no later than 3 tck edges after N.
- Simultaneous push and pop: both happen; count stays consistent; no word is lost or duplicated.
- Wrap-around: pointers roll over modulo 2*DEPTH; data order is preserved across the wrap.
- v_cdr, v_sdr and v_udr are mutually exclusive; if asserted together, priority is cdr > sdr > udr.

Test Plan:
- Reset: hold aclr low, then release -> full=0, overflow=0, tdo=0. STATUS scan reads 9'h001 (empty, count 0).
- Push 0xA5, 0x3C, 0x7E, then 3 DATA scans -> tdo streams 9'h14B, 9'h079, 9'h0FD (LSB valid=1) in order. Then a STATUS scan reads 9'h001.
- Empty read: DATA scan on empty FIFO -> 9'h000. A second STATUS scan still reads count 0, and rptr is unchanged.
- Fill: push 16 words 0x00..0x0F -> full=1 after the 16th. A 17th push (0xFF) -> dropped, overflow=1. STATUS reads count=16, overflow=1, full=1, empty=0 = 9'h086. DATA reads return 0x00..0x0F, and full=0 within 3 clk after the first pop.
- Aborted pop: DATA capture of a non-empty FIFO, then IR switched to STATUS before udr -> no pop. The next DATA scan returns the same word.
- Bypass plus mid-scan reset:
  - IR=0: tdi pattern 1011 appears on tdo delayed by 1 tck.
  - aclr pulsed mid DATA shift -> sr=0, pointers=0, and a STATUS scan reads 9'h001.
- Wrap and concurrency: 40 pushes and pops with clk/tck ratio 3:7 -> all 40 words are received in order, with no loss or duplication.
